// File: rtl/seq_alu.sv
// Handshaked ALU: single-cycle add/sub/logic/shift plus iterative unsigned
// shift-add multiply and restoring divide, one bit per cycle.
module seq_alu #(
    parameter int NBITS = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [NBITS-1:0] A,
    input  logic [NBITS-1:0] B,
    input  logic [3:0]       opcode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [NBITS-1:0] result,
    output logic [NBITS-1:0] result_hi,
    output logic             carryout,
    output logic             overflow,
    output logic             zero,
    output logic             error
);
    localparam int SW = $clog2(NBITS);

    localparam logic [3:0] OP_ADDU = 4'b0000;
    localparam logic [3:0] OP_ADDS = 4'b0001;
    localparam logic [3:0] OP_SUBU = 4'b0010;
    localparam logic [3:0] OP_SUBS = 4'b0011;
    localparam logic [3:0] OP_AND  = 4'b0100;
    localparam logic [3:0] OP_OR   = 4'b0101;
    localparam logic [3:0] OP_XOR  = 4'b0110;
    localparam logic [3:0] OP_ASR  = 4'b0111;
    localparam logic [3:0] OP_MUL  = 4'b1000;
    localparam logic [3:0] OP_DIV  = 4'b1001;
    localparam logic [3:0] OP_SHL  = 4'b1010;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state, state_next;
    logic [SW-1:0]    count;
    logic             iter_done, is_div;
    logic [NBITS-1:0] work_hi, work_lo, b_reg;
    logic [NBITS-1:0] step_hi, step_lo;
    logic             start, load_sc, load_mc;

    function automatic logic add_ovf(input logic a_msb, input logic b_msb, input logic r_msb);
        return (a_msb == b_msb) && (r_msb != a_msb);
    endfunction

    function automatic logic sub_ovf(input logic a_msb, input logic b_msb, input logic r_msb);
        return (a_msb != b_msb) && (r_msb != a_msb);
    endfunction

    logic signed [NBITS-1:0] a_s, b_s, sadd, ssub;
    logic [NBITS:0]          add_w, sub_w, shl_w;

    assign a_s   = A;
    assign b_s   = B;
    assign sadd  = a_s + b_s;
    assign ssub  = a_s - b_s;
    assign add_w = {1'b0, A} + {1'b0, B};
    assign sub_w = {1'b0, A} - {1'b0, B};
    // Bit NBITS of the widened shift is exactly the last bit pushed out.
    assign shl_w = {1'b0, A} << B[SW-1:0];

    logic [NBITS-1:0] sc_res, sc_hi;
    logic             sc_c, sc_v, sc_e;

    always_comb begin
        sc_res = '0;
        sc_hi  = '0;
        sc_c   = 1'b0;
        sc_v   = 1'b0;
        sc_e   = 1'b0;
        case (opcode)
            OP_ADDU: begin sc_res = add_w[NBITS-1:0]; sc_c = add_w[NBITS]; end
            OP_ADDS: begin sc_res = sadd; sc_v = add_ovf(A[NBITS-1], B[NBITS-1], sadd[NBITS-1]); end
            OP_SUBU: begin sc_res = sub_w[NBITS-1:0]; sc_c = sub_w[NBITS]; end
            OP_SUBS: begin sc_res = ssub; sc_v = sub_ovf(A[NBITS-1], B[NBITS-1], ssub[NBITS-1]); end
            OP_AND:  sc_res = A & B;
            OP_OR:   sc_res = A | B;
            OP_XOR:  sc_res = A ^ B;
            OP_ASR:  sc_res = a_s >>> 1;
            OP_SHL:  begin sc_res = shl_w[NBITS-1:0]; sc_c = shl_w[NBITS]; end
            OP_MUL:  begin end
            // Only reached here with B == 0; nonzero divisors iterate.
            OP_DIV:  begin sc_res = '1; sc_hi = A; sc_e = 1'b1; end
            default: begin sc_res = '1; sc_e = 1'b1; end
        endcase
    end

    logic [NBITS:0]   m_sum, d_shift;
    logic [NBITS-1:0] d_diff;
    logic             d_fit;

    assign m_sum   = {1'b0, work_hi} + (work_lo[0] ? {1'b0, b_reg} : '0);
    assign d_shift = {work_hi, work_lo[NBITS-1]};
    assign d_fit   = (d_shift >= {1'b0, b_reg});
    // When d_fit holds the true difference is below B, so the low bits suffice.
    assign d_diff  = d_shift[NBITS-1:0] - b_reg;

    always_comb begin
        if (is_div) begin
            step_hi = d_fit ? d_diff : d_shift[NBITS-1:0];
            step_lo = {work_lo[NBITS-2:0], d_fit};
        end else begin
            step_hi = m_sum[NBITS:1];
            step_lo = {m_sum[0], work_lo[NBITS-1:1]};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        start      = 1'b0;
        load_sc    = 1'b0;
        load_mc    = 1'b0;
        case (state)
            IDLE: if (in_valid) begin
                if (opcode == OP_MUL || (opcode == OP_DIV && B != '0)) begin
                    start      = 1'b1;
                    state_next = BUSY;
                end else begin
                    load_sc    = 1'b1;
                    state_next = DONE;
                end
            end
            BUSY: if (iter_done) begin
                load_mc    = 1'b1;
                state_next = DONE;
            end
            DONE: if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count     <= '0;
            iter_done <= 1'b0;
            is_div    <= 1'b0;
        end else if (start) begin
            count     <= SW'(NBITS - 1);
            iter_done <= 1'b0;
            is_div    <= opcode[0];
        end else if (state == BUSY && !iter_done) begin
            if (count == '0) iter_done <= 1'b1;
            else             count     <= count - 1'b1;
        end
    end

    // Working registers carry data only; the FSM guarantees they are loaded before use.
    always_ff @(posedge clk) begin
        if (start) begin
            work_hi <= '0;
            work_lo <= A;
            b_reg   <= B;
        end else if (state == BUSY && !iter_done) begin
            work_hi <= step_hi;
            work_lo <= step_lo;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            result    <= '0;
            result_hi <= '0;
            carryout  <= 1'b0;
            overflow  <= 1'b0;
            zero      <= 1'b0;
            error     <= 1'b0;
        end else if (load_sc) begin
            result    <= sc_res;
            result_hi <= sc_hi;
            carryout  <= sc_c;
            overflow  <= sc_v;
            zero      <= (sc_res == '0);
            error     <= sc_e;
        end else if (load_mc) begin
            result    <= work_lo;
            result_hi <= work_hi;
            carryout  <= !is_div && (work_hi != '0);
            overflow  <= 1'b0;
            zero      <= (work_lo == '0);
            error     <= 1'b0;
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu at NBITS=8: expectations are queued at issue
// and popped when out_valid is seen.
module tb_seq_alu;
    localparam int NBITS = 8;

    logic             clk, reset, in_valid, in_ready, out_valid, out_ready;
    logic [NBITS-1:0] A, B, result, result_hi;
    logic [3:0]       opcode;
    logic             carryout, overflow, zero, error;

    // Field order: result, result_hi, carryout, overflow, zero, error
    typedef struct packed {
        logic [7:0] res;
        logic [7:0] hi;
        logic       c, v, z, e;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    seq_alu #(.NBITS(NBITS)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .opcode(opcode), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .result_hi(result_hi), .carryout(carryout),
        .overflow(overflow), .zero(zero), .error(error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
        exp_t e;
        int s, sa, sb, p, sh;
        e  = '0;
        sa = a[7] ? int'(a) - 256 : int'(a);
        sb = b[7] ? int'(b) - 256 : int'(b);
        case (op)
            4'd0: begin s = a + b; e.res = s[7:0]; e.c = (s > 255); end
            4'd1: begin s = sa + sb; e.res = s[7:0]; e.v = (s > 127 || s < -128); end
            4'd2: begin e.res = a - b; e.c = (a < b); end
            4'd3: begin s = sa - sb; e.res = s[7:0]; e.v = (s > 127 || s < -128); end
            4'd4: e.res = a & b;
            4'd5: e.res = a | b;
            4'd6: e.res = a ^ b;
            4'd7: e.res = {a[7], a[7:1]};
            4'd8: begin p = a * b; e.res = p[7:0]; e.hi = p[15:8]; e.c = (e.hi != 0); end
            4'd9: begin
                if (b == 0) begin e.res = 8'hFF; e.hi = a; e.e = 1'b1; end
                else begin e.res = a / b; e.hi = a % b; end
            end
            4'd10: begin
                sh = int'(b[2:0]);
                e.res = a << sh;
                e.c = (sh == 0) ? 1'b0 : a[8 - sh];
            end
            default: begin e.res = 8'hFF; e.e = 1'b1; end
        endcase
        e.z = (e.res == 0);
        return e;
    endfunction

    task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op, input exp_t e);
        int w = 0;
        while (!in_ready && w < 40) begin @(posedge clk); #1; w++; end
        A = a; B = b; opcode = op; in_valid = 1'b1;
        sb_q.push_back(e);
        @(posedge clk); #1;
        in_valid = 1'b0;
        A = ~a; B = ~b; opcode = 4'b1111;
    endtask

    // Waits for out_valid (lat = edges after accept, -1 on timeout) and pops the expectation.
    task automatic collect(output exp_t got, output exp_t exp, output int lat);
        lat = 0;
        while (!out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
        if (!out_valid) lat = -1;
        got = {result, result_hi, carryout, overflow, zero, error};
        if (sb_q.size() > 0) exp = sb_q.pop_front();
        else exp = '1;
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        exp_t got;
        repeat (2) @(posedge clk);
        #1;
        got = {result, result_hi, carryout, overflow, zero, error};
        n_tests++;
        if (got !== '0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: got outs=%h rdy=%b vld=%b required 0 1 0", got, in_ready, out_valid);
        end
        reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_add();
        exp_t got, exp; int lat;
        issue(8'hFF, 8'h01, 4'b0000, {8'h00, 8'h00, 4'b1010});
        collect(got, exp, lat);
        n_tests++;
        if (got !== exp) begin n_fail++; $display("FAIL addu_ff_01: got %h required %h", got, exp); end
        n_tests++;
        if (lat != 0) begin n_fail++; $display("FAIL addu_latency: got %0d required 0", lat); end
        release_out();
    endtask

    task automatic test_signed();
        exp_t got, exp; int lat;
        issue(8'h80, 8'h01, 4'b0011, {8'h7F, 8'h00, 4'b0100});
        collect(got, exp, lat);
        n_tests++;
        if (got !== exp) begin n_fail++; $display("FAIL subs_80_01: got %h required %h", got, exp); end
        release_out();
        issue(8'h7F, 8'h01, 4'b0001, {8'h80, 8'h00, 4'b0100});
        collect(got, exp, lat);
        n_tests++;
        if (got !== exp) begin n_fail++; $display("FAIL adds_7f_01: got %h required %h", got, exp); end
        release_out();
    endtask

    task automatic test_mul();
        exp_t got, exp; int lat;
        issue(8'hFF, 8'hFF, 4'b1000, {8'h01, 8'hFE, 4'b1000});
        collect(got, exp, lat);
        n_tests++;
        if (got !== exp) begin n_fail++; $display("FAIL mul_ff_ff: got %h required %h", got, exp); end
        n_tests++;
        if (lat != NBITS + 1) begin n_fail++; $display("FAIL mul_latency: got %0d required %0d", lat, NBITS + 1); end
        release_out();
        issue(8'h0F, 8'h11, 4'b1000, {8'hFF, 8'h00, 4'b0000});
        collect(got, exp, lat);
        n_tests++;
        if (got !== exp) begin n_fail++; $display("FAIL mul_0f_11: got %h required %h", got, exp); end
        release_out();
        issue(8'hB7, 8'h5D, 4'b1000, model(8'hB7, 8'h5D, 4'b1000));
        collect(got, exp, lat);
        n_tests++;
        if (got !== exp) begin n_fail++; $display("FAIL mul_b7_5d: got %h required %h", got, exp); end
        release_out();
    endtask

    task automatic test_div();
        exp_t got, exp; int lat;
        issue(8'd100, 8'd7, 4'b1001, {8'd14, 8'd2, 4'b0000});
        collect(got, exp, lat);
        n_tests++;
        if (got !== exp) begin n_fail++; $display("FAIL div_100_7: got %h required %h", got, exp); end
        n_tests++;
        if (lat != NBITS + 1) begin n_fail++; $display("FAIL div_latency: got %0d required %0d", lat, NBITS + 1); end
        release_out();
        issue(8'hF3, 8'h0D, 4'b1001, model(8'hF3, 8'h0D, 4'b1001));
        collect(got, exp, lat);
        n_tests++;
        if (got !== exp) begin n_fail++; $display("FAIL div_f3_0d: got %h required %h", got, exp); end
        release_out();
        issue(8'h55, 8'h00, 4'b1001, {8'hFF, 8'h55, 4'b0001});
        collect(got, exp, lat);
        n_tests++;
        if (got !== exp) begin n_fail++; $display("FAIL div_by_zero: got %h required %h", got, exp); end
        n_tests++;
        if (lat != 0) begin n_fail++; $display("FAIL div0_latency: got %0d required 0", lat); end
        release_out();
        issue(8'h12, 8'h34, 4'b1100, {8'hFF, 8'h00, 4'b0001});
        collect(got, exp, lat);
        n_tests++;
        if (got !== exp) begin n_fail++; $display("FAIL illegal_op: got %h required %h", got, exp); end
        release_out();
    endtask

    task automatic test_logic_shift();
        exp_t got, exp; int lat;
        logic [7:0] av[6] = '{8'h81, 8'h80, 8'hF0, 8'hC3, 8'hC3, 8'hC3};
        logic [7:0] bv[6] = '{8'h01, 8'h00, 8'h00, 8'h3C, 8'h3C, 8'h0F};
        logic [3:0] ov[6] = '{4'd10, 4'd7, 4'd10, 4'd4, 4'd5, 4'd6};
        for (int i = 0; i < 6; i++) begin
            issue(av[i], bv[i], ov[i], model(av[i], bv[i], ov[i]));
            collect(got, exp, lat);
            n_tests++;
            if (got !== exp) begin n_fail++; $display("FAIL logic_shift_%0d: got %h required %h", i, got, exp); end
            release_out();
        end
    endtask

    task automatic test_backpressure();
        exp_t got, exp, pend; int lat;
        issue(8'h03, 8'h04, 4'b0000, {8'h07, 8'h00, 4'b0000});
        collect(got, exp, lat);
        n_tests++;
        if (got !== exp) begin n_fail++; $display("FAIL bp_first: got %h required %h", got, exp); end
        A = 8'h09; B = 8'h01; opcode = 4'b0010; in_valid = 1'b1;
        pend = {8'h08, 8'h00, 4'b0000};
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            got = {result, result_hi, carryout, overflow, zero, error};
            n_tests++;
            if (got !== exp || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold_%0d: got %h vld=%b rdy=%b required %h 1 0", i, got, out_valid, in_ready, exp);
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        n_tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL bp_release: got rdy=%b vld=%b required 1 0", in_ready, out_valid);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        got = {result, result_hi, carryout, overflow, zero, error};
        n_tests++;
        if (got !== pend || out_valid !== 1'b1) begin
            n_fail++; $display("FAIL bp_pending: got %h vld=%b required %h 1", got, out_valid, pend);
        end
        release_out();
    endtask

    task automatic test_reset_mid_mul();
        exp_t got, exp; int lat;
        issue(8'hAB, 8'hCD, 4'b1000, model(8'hAB, 8'hCD, 4'b1000));
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        got = {result, result_hi, carryout, overflow, zero, error};
        n_tests++;
        if (got !== '0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_mid_mul: got %h vld=%b rdy=%b required 0 0 1", got, out_valid, in_ready);
        end
        sb_q.delete();
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        issue(8'h12, 8'h34, 4'b0000, {8'h46, 8'h00, 4'b0000});
        collect(got, exp, lat);
        n_tests++;
        if (got !== exp || lat != 0) begin
            n_fail++; $display("FAIL add_after_reset: got %h lat=%0d required %h 0", got, lat, exp);
        end
        release_out();
    endtask

    task automatic test_back_to_back();
        exp_t got, exp;
        logic [7:0] a, b;
        logic [3:0] op;
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            a  = 8'($urandom_range(0, 255));
            b  = 8'($urandom_range(0, 255));
            op = 4'($urandom_range(0, 15));
            if (op == 4'd8 || op == 4'd9) op = 4'd10;
            exp = model(a, b, op);
            A = a; B = b; opcode = op; in_valid = 1'b1;
            @(posedge clk); #1;
            A = ~a; B = ~b;
            got = {result, result_hi, carryout, overflow, zero, error};
            n_tests++;
            if (got !== exp || out_valid !== 1'b1) begin
                n_fail++; $display("FAIL b2b_%0d op=%0d a=%h b=%h: got %h vld=%b required %h 1", k, op, a, b, got, out_valid, exp);
            end
            @(posedge clk); #1;
            n_tests++;
            if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
                n_fail++; $display("FAIL b2b_return_%0d: got rdy=%b vld=%b required 1 0", k, in_ready, out_valid);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
    endtask

    initial begin
        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        A = '0; B = '0; opcode = '0;
        test_reset();
        test_add();
        test_signed();
        test_mul();
        test_div();
        test_logic_shift();
        test_backpressure();
        test_reset_mid_mul();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
